// File: rtl/data_cache.sv
// Direct-mapped write-back/write-allocate data cache with an MMIO bypass at 0xFC.
// Optional hit/miss statistics counters are built when DATA_CACHE_STATS_EN is defined.
module data_cache #(
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 256
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [31:0]           i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic                  i_we,
  input  logic [1:0]            i_size,
  input  logic                  i_load_unsigned,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_stall,
  output logic                  o_mem_fetch,
  output logic [31:0]           o_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_mem_writeback,
  output logic [31:0]           o_mem_wb_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wb_data,
  output logic [31:0]           o_hit_count,
  output logic [31:0]           o_miss_count
);
  localparam int          IDX_W = $clog2(SETS);
  localparam int          TAG_W = 32 - IDX_W - 2;
  localparam logic [31:0] MMIO  = 32'h0000_00FC;

  typedef enum logic [1:0] {S_IDLE, S_WB, S_ALLOC} state_t;

  state_t                  r_state;
  logic [SETS-1:0]         r_valid, r_dirty;
  logic [TAG_W-1:0]        r_tag  [SETS];
  logic [DATA_WIDTH-1:0]   r_data [SETS];

  logic [IDX_W-1:0]        w_idx;
  logic [TAG_W-1:0]        w_tag;
  logic                    w_req, w_mmio, w_creq, w_hit;
  logic [DATA_WIDTH-1:0]   w_line, w_lane, w_merged;
  logic [7:0]              w_byte;
  logic [15:0]             w_half;

  assign w_idx  = i_addr[IDX_W+1:2];
  assign w_tag  = i_addr[31:IDX_W+2];
  assign w_req  = i_re | i_we;
  assign w_mmio = (i_addr == MMIO);
  assign w_creq = w_req & ~w_mmio;
  assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_line = r_data[w_idx];
  assign w_byte = w_line[{i_addr[1:0], 3'b000} +: 8];
  assign w_half = i_addr[1] ? w_line[31:16] : w_line[15:0];

  always_comb begin
    w_lane = w_line;
    case (i_size)
      2'b00:   w_lane = {{24{~i_load_unsigned & w_byte[7]}}, w_byte};
      2'b01:   w_lane = {{16{~i_load_unsigned & w_half[15]}}, w_half};
      default: w_lane = w_line;
    endcase
  end

  always_comb begin
    w_merged = w_line;
    case (i_size)
      2'b00: w_merged[{i_addr[1:0], 3'b000} +: 8] = i_wdata[7:0];
      2'b01: begin
        if (i_addr[1]) w_merged[31:16] = i_wdata[15:0];
        else           w_merged[15:0]  = i_wdata[15:0];
      end
      default: w_merged = i_wdata;
    endcase
  end

  // Outputs are gated by reset so stall/strobes drop the instant reset rises.
  always_comb begin
    o_rdata         = '0;
    o_stall         = 1'b0;
    o_mem_fetch     = 1'b0;
    o_mem_addr      = '0;
    o_mem_writeback = 1'b0;
    o_mem_wb_addr   = '0;
    o_mem_wb_data   = '0;
    if (!i_rst) begin
      case (r_state)
        S_IDLE: begin
          if (w_req && w_mmio) begin
            if (!i_we) begin
              o_mem_fetch = 1'b1;
              o_mem_addr  = MMIO;
              o_rdata     = i_mem_rdata;
            end
          end else if (w_req) begin
            if (!w_hit)     o_stall = 1'b1;
            else if (!i_we) o_rdata = w_lane;
          end
        end
        S_WB: begin
          o_stall         = 1'b1;
          o_mem_writeback = 1'b1;
          o_mem_wb_addr   = {r_tag[w_idx], w_idx, 2'b00};
          o_mem_wb_data   = w_line;
        end
        S_ALLOC: begin
          o_stall     = 1'b1;
          o_mem_fetch = 1'b1;
          o_mem_addr  = {i_addr[31:2], 2'b00};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_creq) begin
            if (w_hit) begin
              if (i_we) r_dirty[w_idx] <= 1'b1;
            end else begin
              r_state <= r_dirty[w_idx] ? S_WB : S_ALLOC;
            end
          end
        end
        S_WB: r_state <= S_ALLOC;
        S_ALLOC: begin
          r_valid[w_idx] <= 1'b1;
          r_dirty[w_idx] <= 1'b0;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tag/data storage carries no reset; valid bits alone qualify it.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (r_state == S_IDLE && w_creq && w_hit && i_we)
        r_data[w_idx] <= w_merged;
      else if (r_state == S_ALLOC) begin
        r_data[w_idx] <= i_mem_rdata;
        r_tag[w_idx]  <= w_tag;
      end
    end
  end

`ifdef DATA_CACHE_STATS_EN
  logic [31:0] r_hit_count, r_miss_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (r_state == S_IDLE && w_creq) begin
      if (w_hit) r_hit_count  <= r_hit_count + 32'd1;
      else       r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign o_hit_count  = r_hit_count;
  assign o_miss_count = r_miss_count;
`else
  assign o_hit_count  = '0;
  assign o_miss_count = '0;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Randomized bench for data_cache against an architectural memory + tag-state model.
module tb_data_cache;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] addr = '0, wdata = '0;
  logic        re = 1'b0, we = 1'b0, load_unsigned = 1'b0;
  logic [1:0]  size = 2'b10;
  logic [31:0] rdata, mem_addr, mem_rdata, mem_wb_addr, mem_wb_data, hit_count, miss_count;
  logic        stall, mem_fetch, mem_writeback;

  int checks = 0, errors = 0;

  logic [31:0] mem  [0:65535];  // physical memory seen by the DUT
  logic [31:0] arch [0:65535];  // what a program would observe
  bit          mvalid [256];
  bit          mdirty [256];
  logic [21:0] mtag   [256];
  int unsigned mhits = 0, mmiss = 0;

  data_cache dut (
    .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_wdata(wdata), .i_re(re), .i_we(we),
    .i_size(size), .i_load_unsigned(load_unsigned), .o_rdata(rdata), .o_stall(stall),
    .o_mem_fetch(mem_fetch), .o_mem_addr(mem_addr), .i_mem_rdata(mem_rdata),
    .o_mem_writeback(mem_writeback), .o_mem_wb_addr(mem_wb_addr), .o_mem_wb_data(mem_wb_data),
    .o_hit_count(hit_count), .o_miss_count(miss_count)
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[17:2]];
  always @(posedge clk) if (mem_writeback) mem[mem_wb_addr[17:2]] <= mem_wb_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ext(logic [31:0] w, logic [1:0] sz, logic [1:0] off, bit u);
    int nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    int sh = (nb == 4) ? 0 : (int'(off) / nb) * nb * 8;
    logic [31:0] mask, v;
    if (nb == 4) return w;
    mask = (32'h1 << (nb * 8)) - 32'h1;
    v = (w >> sh) & mask;
    if (!u && v[nb*8-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] w, logic [31:0] d, logic [1:0] sz, logic [1:0] off);
    int nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    int sh = (nb == 4) ? 0 : (int'(off) / nb) * nb * 8;
    logic [31:0] mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (nb * 8)) - 32'h1) << sh;
    return (w & ~mask) | ((d << sh) & mask);
  endfunction

  task automatic chk_counters(input string tag);
`ifdef DATA_CACHE_STATS_EN
    chk({tag, "_hits"}, hit_count, mhits);
    chk({tag, "_miss"}, miss_count, mmiss);
`else
    chk({tag, "_hits"}, hit_count, 32'd0);
    chk({tag, "_miss"}, miss_count, 32'd0);
`endif
  endtask

  task automatic op(input bit w, input bit r, input logic [1:0] sz, input bit u,
                    input logic [31:0] a, input logic [31:0] wd,
                    output logic [31:0] rd, output int lat);
    logic [7:0]  set = a[9:2];
    logic [21:0] tg  = a[31:10];
    bit          mmio = (a == 32'hFC);
    int          explat, nf = 0, nwb = 0;
    logic [31:0] ewa = '0, ewd = '0, fa = '0, wa = '0, wdat = '0;
    bit          both = 0;
    if (mmio)                                  explat = 0;
    else if (mvalid[set] && mtag[set] == tg)   explat = 0;
    else if (mdirty[set]) begin
      explat = 3;
      ewa = {mtag[set], set, 2'b00};
      ewd = arch[ewa[17:2]];
    end else                                   explat = 2;

    @(negedge clk);
    addr = a; wdata = wd; we = w; re = r; size = sz; load_unsigned = u;
    #1;
    lat = 0;
    while (stall && lat < 8) begin
      if (mem_writeback) begin nwb++; wa = mem_wb_addr; wdat = mem_wb_data; end
      if (mem_fetch) begin nf++; fa = mem_addr; end
      if (mem_fetch && mem_writeback) both = 1;
      @(posedge clk); #1;
      lat++;
    end
    rd = rdata;
    chk("latency", lat, explat);
    chk("strobe_overlap", {31'd0, both}, 32'd0);
    if (!mmio && explat > 0) begin
      chk("fetch_n", nf, 1);
      chk("fetch_addr", fa, {a[31:2], 2'b00});
      chk("wb_n", nwb, (explat == 3) ? 1 : 0);
      if (explat == 3) begin
        chk("wb_addr", wa, ewa);
        chk("wb_data", wdat, ewd);
      end
    end
    if (mmio && !w) begin
      chk("mmio_fetch", {31'd0, mem_fetch}, 32'd1);
      chk("mmio_addr", mem_addr, 32'hFC);
      chk("mmio_rdata", rd, mem[63]);
    end else begin
      chk("hit_strobes", {30'd0, mem_fetch, mem_writeback}, 32'd0);
      if (!w) chk("load_rdata", rd, ext(arch[a[17:2]], sz, a[1:0], u));
    end

    if (!mmio) begin
      if (explat > 0) begin
        mmiss++;
        mvalid[set] = 1; mtag[set] = tg; mdirty[set] = 0;
      end
      mhits++;
      if (w) begin
        arch[a[17:2]] = merge(arch[a[17:2]], wd, sz, a[1:0]);
        mdirty[set] = 1;
      end
    end
    @(posedge clk); #1;
    re = 0; we = 0;
    chk_counters("cnt");
  endtask

  task automatic rand_ops(input int n);
    logic [31:0] a, rd;
    int lat;
    bit w, r;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(49) == 0) a = 32'hFC;
      else a = 32'h10000 + $urandom_range(3) * 32'h400 + $urandom_range(7) * 4 + $urandom_range(3);
      w = $urandom_range(1);
      r = w ? bit'($urandom_range(1)) : 1'b1;
      op(w, r, 2'($urandom_range(3)), bit'($urandom_range(1)), a, $urandom, rd, lat);
    end
  endtask

  initial begin
    logic [31:0] rd;
    int lat, k;
    for (int i = 0; i < 65536; i++) mem[i] <= $urandom;
    mem[32'h10000 >> 2] <= 32'h1122_3344;
    mem[32'h10800 >> 2] <= 32'h8001_8080;
    mem[63]             <= 32'h0000_0001;
    #1;
    for (int i = 0; i < 65536; i++) arch[i] = mem[i];
    for (int i = 0; i < 256; i++) begin mvalid[i] = 0; mdirty[i] = 0; mtag[i] = '0; end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_strobes", {30'd0, mem_fetch, mem_writeback}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_maddr", mem_addr, 32'd0);
    chk("rst_wbaddr", mem_wb_addr, 32'd0);
    chk_counters("rst");
    @(negedge clk); rst = 0;

    op(0, 1, 2'b10, 0, 32'h10000, 0, rd, lat);
    chk("rdmiss_lat", lat, 2);  chk("rdmiss_data", rd, 32'h1122_3344);
    op(0, 1, 2'b10, 0, 32'h10000, 0, rd, lat);
    chk("rdhit_lat", lat, 0);
    op(1, 0, 2'b00, 0, 32'h10001, 32'hAB, rd, lat);
    op(0, 1, 2'b10, 0, 32'h10000, 0, rd, lat);
    chk("sb_data", rd, 32'h1122_AB44);
    op(0, 1, 2'b10, 0, 32'h10400, 0, rd, lat);
    chk("evict_lat", lat, 3);
    chk("evict_mem", mem[32'h10000 >> 2], 32'h1122_AB44);
    op(0, 1, 2'b10, 0, 32'h10000, 0, rd, lat);
    chk("reload", rd, 32'h1122_AB44);
    op(0, 1, 2'b00, 0, 32'h10800, 0, rd, lat);  chk("lb", rd, 32'hFFFF_FF80);
    op(0, 1, 2'b00, 1, 32'h10800, 0, rd, lat);  chk("lbu", rd, 32'h0000_0080);
    op(0, 1, 2'b01, 0, 32'h10802, 0, rd, lat);  chk("lh", rd, 32'hFFFF_8001);
    op(0, 1, 2'b10, 0, 32'hFC, 0, rd, lat);
    chk("mmio_lat", lat, 0);  chk("mmio_val", rd, 32'h1);
    op(1, 0, 2'b10, 0, 32'hFC, 32'hDEAD, rd, lat);
    op(0, 1, 2'b10, 0, 32'h10800, 0, rd, lat);
    chk("after_mmio_lat", lat, 0);

    rand_ops(300);

    // Reset while the refill is in flight.
    @(negedge clk);
    addr = 32'h12000; re = 1; we = 0; size = 2'b10;
    #1;
    k = 0;
    while (!mem_fetch && k < 6) begin @(posedge clk); #1; k++; end
    chk("alloc_reached", {31'd0, mem_fetch}, 32'd1);
    #2 rst = 1;
    #1;
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    chk("midrst_fetch", {31'd0, mem_fetch}, 32'd0);
    re = 0;
    @(posedge clk); #1;
    mhits = 0; mmiss = 0;
    for (int i = 0; i < 256; i++) begin mvalid[i] = 0; mdirty[i] = 0; end
    for (int i = 0; i < 65536; i++) arch[i] = mem[i];
    chk_counters("midrst");
    @(negedge clk); rst = 0;
    op(0, 1, 2'b10, 0, 32'h10000, 0, rd, lat);
    chk("postrst_lat", lat, 2);

    rand_ops(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
